// File: rtl/traffic_phase_scheduler.sv
// Round-robin intersection phase scheduler: green -> yellow -> all-red per granted approach.
// Optional pedestrian walk phase is compiled in with `define PED_WALK_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_ALL_RED | every approach red; waits for clearance plus a pending request
// S_GREEN   | grant_idx approach green, held MIN_GREEN..MAX_GREEN cycles
// S_YELLOW  | grant_idx approach yellow for exactly YELLOW_T cycles
// S_WALK    | pedestrian walk, all approaches red, WALK_T cycles (macro only)
module traffic_phase_scheduler #(
   parameter int N_APP     = 4,
   parameter int MIN_GREEN = 4,
   parameter int MAX_GREEN = 12,
   parameter int YELLOW_T  = 2,
   parameter int ALL_RED_T = 1,
   parameter int WALK_T    = 6,
   parameter int CNT_W     = 4,
   localparam int IDX_W    = $clog2(N_APP)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_APP-1:0] req,
   input  logic             ped_req,
   output logic [N_APP-1:0] green,
   output logic [N_APP-1:0] yellow,
   output logic [N_APP-1:0] red,
   output logic             walk,
   output logic [IDX_W-1:0] grant_idx
);

`ifdef PED_WALK_EN
   typedef enum logic [1:0] {S_ALL_RED, S_GREEN, S_YELLOW, S_WALK} state_t;
`else
   typedef enum logic [1:0] {S_ALL_RED, S_GREEN, S_YELLOW} state_t;
`endif

   localparam logic [CNT_W:0] MIN_GREEN_E = (CNT_W+1)'(MIN_GREEN);
   localparam logic [CNT_W:0] MAX_GREEN_E = (CNT_W+1)'(MAX_GREEN);
   localparam logic [CNT_W:0] YELLOW_E    = (CNT_W+1)'(YELLOW_T);
   localparam logic [CNT_W:0] ALL_RED_E   = (CNT_W+1)'(ALL_RED_T);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   grant_q, grant_d;
   logic [CNT_W:0]     elapsed;
   logic [N_APP-1:0]   grant_oh;
   logic               others_req;
   logic               rr_found;
   logic [IDX_W-1:0]   rr_idx;
   logic [IDX_W-1:0]   cand;
   logic               ped_pend;
   logic               ped_clr;

   assign elapsed    = {1'b0, cnt_q} + (CNT_W+1)'(1);
   assign grant_oh   = N_APP'(1) << grant_q;
   assign others_req = |(req & ~grant_oh);

`ifdef PED_WALK_EN
   localparam logic [CNT_W:0] WALK_E = (CNT_W+1)'(WALK_T);
   logic ped_pend_q, ped_pend_d;
   logic ped_prev_q, ped_prev_d;

   assign ped_pend = ped_pend_q;

   always_comb begin
      ped_prev_d = ped_req;
      ped_pend_d = (ped_pend_q & ~ped_clr) | (ped_req & ~ped_prev_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ped_pend_q <= 1'b0;
         ped_prev_q <= 1'b0;
      end else begin
         ped_pend_q <= ped_pend_d;
         ped_prev_q <= ped_prev_d;
      end
   end
`else
   logic ped_unused;
   assign ped_unused = ped_req;
   assign ped_pend   = 1'b0;
`endif

   // Search starts just after the last-served approach, so it is checked last.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = grant_q;
      cand     = grant_q;
      for (int i = 1; i <= N_APP; i++) begin
         cand = IDX_W'((int'(grant_q) + i) % N_APP);
         if (!rr_found && req[cand]) begin
            rr_found = 1'b1;
            rr_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ped_clr = 1'b0;
      case (state_q)
         S_ALL_RED: begin
            if (elapsed >= ALL_RED_E) begin
               if (ped_pend) begin
`ifdef PED_WALK_EN
                  state_d = S_WALK;
                  ped_clr = 1'b1;
`endif
               end else if (rr_found) begin
                  state_d = S_GREEN;
                  grant_d = rr_idx;
               end
            end
         end
         S_GREEN: begin
            if (elapsed == MAX_GREEN_E ||
                (elapsed >= MIN_GREEN_E && (!req[grant_q] || others_req || ped_pend)))
               state_d = S_YELLOW;
         end
         S_YELLOW: begin
            if (elapsed >= YELLOW_E) state_d = S_ALL_RED;
         end
`ifdef PED_WALK_EN
         S_WALK: begin
            if (elapsed >= WALK_E) state_d = S_ALL_RED;
         end
`endif
         default: state_d = S_ALL_RED;
      endcase

      // Timer restarts on every state change and saturates while resting.
      if (state_d != state_q)          cnt_d = '0;
      else if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      else                             cnt_d = cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_ALL_RED;
         cnt_q   <= '0;
         grant_q <= IDX_W'(N_APP-1);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
      end
   end

   always_comb begin
      green  = '0;
      yellow = '0;
      if (state_q == S_GREEN)  green  = grant_oh;
      if (state_q == S_YELLOW) yellow = grant_oh;
      red = ~(green | yellow);
   end

`ifdef PED_WALK_EN
   assign walk = (state_q == S_WALK);
`else
   assign walk = 1'b0;
`endif

   assign grant_idx = grant_q;

endmodule
